// File: rtl/fir_stream_sequencer_if.sv
// Stream and filter-side signal bundle for fir_stream_sequencer.
// The master modport is the sequencer's view. The slave modport is the view of
// the surrounding logic: the upstream source, the filter and the downstream sink.
interface fir_stream_sequencer_if #(
  parameter int DATA_WIDTH = 24,
  parameter int CNT_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0] iv_s_data;
  logic                  i_s_valid;
  logic                  o_s_ready;
  logic [DATA_WIDTH-1:0] ov_fir_din;
  logic                  o_fir_din_valid;
  logic                  i_fir_consumed;
  logic [DATA_WIDTH-1:0] iv_fir_dout;
  logic                  i_fir_dout_valid;
  logic                  o_fir_dout_ready;
  logic [DATA_WIDTH-1:0] ov_m_data;
  logic                  o_m_valid;
  logic                  i_m_ready;
  logic                  i_err_clr;
  logic                  o_timeout_err;
  logic [CNT_WIDTH-1:0]  ov_sent_count;
  logic [CNT_WIDTH-1:0]  ov_recv_count;

  modport master (
    input  iv_s_data, i_s_valid, i_fir_consumed, iv_fir_dout, i_fir_dout_valid,
           i_m_ready, i_err_clr,
    output o_s_ready, ov_fir_din, o_fir_din_valid, o_fir_dout_ready, ov_m_data,
           o_m_valid, o_timeout_err, ov_sent_count, ov_recv_count
  );

  modport slave (
    output iv_s_data, i_s_valid, i_fir_consumed, iv_fir_dout, i_fir_dout_valid,
           i_m_ready, i_err_clr,
    input  o_s_ready, ov_fir_din, o_fir_din_valid, o_fir_dout_ready, ov_m_data,
           o_m_valid, o_timeout_err, ov_sent_count, ov_recv_count
  );
endinterface

// File: rtl/fir_stream_sequencer.sv
// Input FIFO plus a one-sample-in-flight sequencer around a single FIR filter.
// Each sample is handed to the filter, the result is awaited (under a watchdog),
// acknowledged and forwarded downstream before the next sample is popped.
module fir_stream_sequencer #(
  parameter int DATA_WIDTH     = 24,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 16
) (
  input logic                    i_clk,
  input logic                    i_rst,
  fir_stream_sequencer_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;
  typedef logic [AW:0]           fcnt_t;
  typedef logic [TW-1:0]         tmr_t;

  localparam fcnt_t DEPTH_C  = fcnt_t'(FIFO_DEPTH);
  localparam tmr_t  TMO_LAST = tmr_t'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_ACK,
    ST_OUT
  } state_t;

  // FIFO state
  data_t         mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  fcnt_t         count_q;
  logic          fifo_avail_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  // Sequencer state and registered outputs
  state_t state_q,    state_d;
  data_t  fir_din_q,  fir_din_d;
  logic   fir_vld_q,  fir_vld_d;
  logic   dout_rdy_q, dout_rdy_d;
  data_t  m_data_q,   m_data_d;
  logic   m_vld_q,    m_vld_d;
  logic   err_q,      err_d;
  cnt_t   sent_q,     sent_d;
  cnt_t   recv_q,     recv_d;
  tmr_t   timer_q,    timer_d;

  assign fifo_full     = (count_q == DEPTH_C);
  assign fifo_empty    = (count_q == '0);
  // No bypass: a full FIFO refuses input even when the head is leaving this cycle.
  assign bus.o_s_ready = !i_rst && !fifo_full;
  assign push          = bus.i_s_valid && bus.o_s_ready;

  // Sample storage; entries are only read after being written, so no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.iv_s_data;
    end
  end

  // Pointers, occupancy and the delayed not-empty flag that gates the pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fifo_avail_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // The sequencer commits to a new sample one cycle after the FIFO
      // reports data, so a fresh sample reaches the filter two edges after
      // it was written.
      fifo_avail_q <= !fifo_empty;
    end
  end

  // Sequencer state register and registered outputs; reset clears all of them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      fir_din_q  <= '0;
      fir_vld_q  <= 1'b0;
      dout_rdy_q <= 1'b0;
      m_data_q   <= '0;
      m_vld_q    <= 1'b0;
      err_q      <= 1'b0;
      sent_q     <= '0;
      recv_q     <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      fir_din_q  <= fir_din_d;
      fir_vld_q  <= fir_vld_d;
      dout_rdy_q <= dout_rdy_d;
      m_data_q   <= m_data_d;
      m_vld_q    <= m_vld_d;
      err_q      <= err_d;
      sent_q     <= sent_d;
      recv_q     <= recv_d;
      timer_q    <= timer_d;
    end
  end

  // Next-state logic: pop, hand to filter, await result, acknowledge, forward.
  always_comb begin
    state_d    = state_q;
    fir_din_d  = fir_din_q;
    fir_vld_d  = fir_vld_q;
    dout_rdy_d = 1'b0;
    m_data_d   = m_data_q;
    m_vld_d    = m_vld_q;
    err_d      = err_q;
    sent_d     = sent_q;
    recv_d     = recv_q;
    timer_d    = timer_q;
    pop        = 1'b0;

    if (bus.i_err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (fifo_avail_q && !fifo_empty) begin
          pop       = 1'b1;
          fir_din_d = mem_q[rd_ptr_q];
          fir_vld_d = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.i_fir_consumed) begin
          fir_vld_d = 1'b0;
          sent_d    = sent_q + 1'b1;
          timer_d   = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (bus.i_fir_dout_valid) begin
          m_data_d   = bus.iv_fir_dout;
          dout_rdy_d = 1'b1;
          state_d    = ST_ACK;
        end else if (timer_q == TMO_LAST) begin
          // Sample is abandoned; a timeout overrides a same-cycle clear.
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        recv_d  = recv_q + 1'b1;
        m_vld_d = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (bus.i_m_ready) begin
          m_vld_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.ov_fir_din       = fir_din_q;
  assign bus.o_fir_din_valid  = fir_vld_q;
  assign bus.o_fir_dout_ready = dout_rdy_q;
  assign bus.ov_m_data        = m_data_q;
  assign bus.o_m_valid        = m_vld_q;
  assign bus.o_timeout_err    = err_q;
  assign bus.ov_sent_count    = sent_q;
  assign bus.ov_recv_count    = recv_q;

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Bench for fir_stream_sequencer: a behavioural filter model, a downstream sink
// with controllable backpressure and a result scoreboard. A second instance
// with 4-bit counters runs in lockstep on the same inputs to observe wrap-around.
module tb_fir_stream_sequencer;

  localparam logic [23:0] FIR_OFS = 24'h000333;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   cons_cyc = 0;
  logic [23:0] exp_q[$];
  bit   bp;
  bit   f_stall;
  bit   f_drop;
  int   f_cons_dly;
  int   f_res_dly;

  fir_stream_sequencer_if #(.DATA_WIDTH(24), .CNT_WIDTH(16)) bus ();
  fir_stream_sequencer_if #(.DATA_WIDTH(24), .CNT_WIDTH(4))  bus2 ();

  fir_stream_sequencer #(
    .DATA_WIDTH(24), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(64), .CNT_WIDTH(16)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  fir_stream_sequencer #(
    .DATA_WIDTH(24), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(64), .CNT_WIDTH(4)
  ) u_dut_w4 (
    .i_clk(clk), .i_rst(rst), .bus(bus2)
  );

  assign bus2.iv_s_data        = bus.iv_s_data;
  assign bus2.i_s_valid        = bus.i_s_valid;
  assign bus2.i_fir_consumed   = bus.i_fir_consumed;
  assign bus2.iv_fir_dout      = bus.iv_fir_dout;
  assign bus2.i_fir_dout_valid = bus.i_fir_dout_valid;
  assign bus2.i_m_ready        = bus.i_m_ready;
  assign bus2.i_err_clr        = bus.i_err_clr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one sample for up to budget cycles; called and returns at a negedge.
  task automatic push(input logic [23:0] d, input bit track, input int budget, output bit ok);
    ok = 1'b0;
    bus.iv_s_data = d;
    bus.i_s_valid = 1'b1;
    for (int k = 0; k < budget; k++) begin
      if (bus.o_s_ready) begin
        ok = 1'b1;
        if (track) exp_q.push_back(d + FIR_OFS);
      end
      @(negedge clk);
      if (ok) break;
    end
    bus.i_s_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Downstream ready, updated just after each rising edge.
  initial begin
    bus.i_m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.i_m_ready = !bp;
    end
  end

  // Filter model: takes the sample, returns sample + FIR_OFS, holds the result until acknowledged.
  initial begin
    logic [23:0] smp;
    bit got_ack;
    bus.i_fir_consumed   = 1'b0;
    bus.i_fir_dout_valid = 1'b0;
    bus.iv_fir_dout      = '0;
    forever begin
      @(negedge clk);
      if (rst || f_stall || !bus.o_fir_din_valid) continue;
      smp = bus.ov_fir_din;
      repeat (f_cons_dly - 1) @(negedge clk);
      bus.i_fir_consumed = 1'b1;
      cons_cyc = cyc;
      @(negedge clk);
      bus.i_fir_consumed = 1'b0;
      if (f_drop) continue;
      repeat (f_res_dly) @(negedge clk);
      bus.iv_fir_dout      = smp + FIR_OFS;
      bus.i_fir_dout_valid = 1'b1;
      got_ack = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (bus.o_fir_dout_ready) begin
          got_ack = 1'b1;
          break;
        end
      end
      chk("fir_ack_seen", got_ack, 1);
      bus.i_fir_dout_valid = 1'b0;
      @(negedge clk);
      chk("fir_ack_one_cycle", bus.o_fir_dout_ready, 0);
    end
  end

  // Scoreboard: compare each accepted downstream result with the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.o_m_valid && bus.i_m_ready) begin
        chk("sb_pending", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("m_data", bus.ov_m_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t reached, expected completion earlier", $time);
    $fatal(1, "simulation did not complete");
  end

  initial begin
    bit ok;
    int n_ok;
    int err_cyc;
    bit stable;
    logic [23:0] held;

    rst = 1'b1; bp = 1'b0; f_stall = 1'b0; f_drop = 1'b0;
    f_cons_dly = 3; f_res_dly = 20;
    bus.iv_s_data = '0; bus.i_s_valid = 1'b0; bus.i_err_clr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_s_ready", bus.o_s_ready, 0);
    chk("rst_din_valid", bus.o_fir_din_valid, 0);
    chk("rst_din", bus.ov_fir_din, 0);
    chk("rst_dout_ready", bus.o_fir_dout_ready, 0);
    chk("rst_m_valid", bus.o_m_valid, 0);
    chk("rst_m_data", bus.ov_m_data, 0);
    chk("rst_err", bus.o_timeout_err, 0);
    chk("rst_sent", bus.ov_sent_count, 0);
    chk("rst_recv", bus.ov_recv_count, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", bus.o_s_ready, 1);

    // Single sample with latency check
    push(24'h000123, 1'b1, 4, ok);
    chk("t1_push", ok, 1);
    chk("t1_lat_e0", bus.o_fir_din_valid, 0);
    @(negedge clk);
    chk("t1_lat_e1", bus.o_fir_din_valid, 0);
    @(negedge clk);
    chk("t1_lat_e2", bus.o_fir_din_valid, 1);
    chk("t1_din", bus.ov_fir_din, 24'h000123);
    drain(200);
    chk("t1_sent", bus.ov_sent_count, 1);
    chk("t1_recv", bus.ov_recv_count, 1);

    // FIFO full with the filter stalled
    f_stall = 1'b1; f_cons_dly = 1; f_res_dly = 2;
    n_ok = 0;
    for (int i = 0; i < 16; i++) begin
      push(24'h100000 + 24'(i), 1'b1, 4, ok);
      if (ok) n_ok++;
    end
    chk("t2_first16", n_ok, 16);
    chk("t2_ready_at_15", bus.o_s_ready, 1);
    chk("t2_head_valid", bus.o_fir_din_valid, 1);
    chk("t2_head_data", bus.ov_fir_din, 24'h100000);
    push(24'h100010, 1'b1, 4, ok);
    chk("t2_refill", ok, 1);
    chk("t2_full_ready", bus.o_s_ready, 0);
    push(24'h1000ff, 1'b1, 5, ok);
    chk("t2_blocked", ok, 0);
    chk("t2_sent_hold", bus.ov_sent_count, 1);
    f_stall = 1'b0;
    drain(2000);
    chk("t2_sent", bus.ov_sent_count, 18);
    chk("t2_recv", bus.ov_recv_count, 18);

    // Timeout, then a normal sample, then clear
    f_drop = 1'b1;
    push(24'h200001, 1'b0, 4, ok);
    err_cyc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.o_timeout_err) begin
        err_cyc = cyc;
        break;
      end
    end
    chk("t3_tmo_latency", err_cyc - (cons_cyc + 1), 64);
    chk("t3_din_valid", bus.o_fir_din_valid, 0);
    chk("t3_m_valid", bus.o_m_valid, 0);
    chk("t3_sent", bus.ov_sent_count, 19);
    chk("t3_recv", bus.ov_recv_count, 18);
    f_drop = 1'b0;
    push(24'h200002, 1'b1, 4, ok);
    drain(300);
    chk("t3_err_sticky", bus.o_timeout_err, 1);
    chk("t3_sent2", bus.ov_sent_count, 20);
    chk("t3_recv2", bus.ov_recv_count, 19);
    bus.i_err_clr = 1'b1;
    @(negedge clk);
    chk("t3_err_clr", bus.o_timeout_err, 0);

    // Timeout while clear is held: the set wins for one cycle
    f_drop = 1'b1;
    push(24'h200003, 1'b0, 4, ok);
    err_cyc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.o_timeout_err) begin
        err_cyc = cyc;
        break;
      end
    end
    chk("t3_set_wins", err_cyc - (cons_cyc + 1), 64);
    @(negedge clk);
    chk("t3_clr_after_set", bus.o_timeout_err, 0);
    bus.i_err_clr = 1'b0; f_drop = 1'b0;
    chk("t3_sent3", bus.ov_sent_count, 21);

    // Downstream backpressure
    bp = 1'b1;
    push(24'h300001, 1'b1, 4, ok);
    for (int k = 0; k < 100; k++) begin
      if (bus.o_m_valid) break;
      @(negedge clk);
    end
    chk("t4_m_valid", bus.o_m_valid, 1);
    held = bus.ov_m_data;
    stable = 1'b1;
    n_ok = 0;
    push(24'h300002, 1'b1, 4, ok);
    if (ok) n_ok++;
    push(24'h300003, 1'b1, 4, ok);
    if (ok) n_ok++;
    chk("t4_fifo_accepts", n_ok, 2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!bus.o_m_valid || bus.ov_m_data !== held || bus.o_fir_din_valid) stable = 1'b0;
    end
    chk("t4_stable", stable, 1);
    chk("t4_held_data", held, 24'h300334);
    chk("t4_sent_hold", bus.ov_sent_count, 22);
    bp = 1'b0;
    drain(300);
    chk("t4_sent", bus.ov_sent_count, 24);
    chk("t4_recv", bus.ov_recv_count, 22);

    // Reset while waiting on the filter with samples queued
    f_drop = 1'b1;
    for (int i = 0; i < 4; i++) push(24'h500000 + 24'(i), 1'b0, 4, ok);
    repeat (5) @(negedge clk);
    chk("t5_in_wait", bus.ov_sent_count, 25);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_s_ready", bus.o_s_ready, 0);
    chk("t5_rst_din_valid", bus.o_fir_din_valid, 0);
    chk("t5_rst_din", bus.ov_fir_din, 0);
    chk("t5_rst_m_data", bus.ov_m_data, 0);
    chk("t5_rst_m_valid", bus.o_m_valid, 0);
    chk("t5_rst_dout_ready", bus.o_fir_dout_ready, 0);
    chk("t5_rst_sent", bus.ov_sent_count, 0);
    chk("t5_rst_recv", bus.ov_recv_count, 0);
    @(negedge clk);
    rst = 1'b0; f_drop = 1'b0;
    @(negedge clk);
    chk("t5_s_ready_after", bus.o_s_ready, 1);
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.o_fir_din_valid) stable = 1'b0;
    end
    chk("t5_fifo_empty", stable, 1);

    // 17 round trips: 16-bit counters read 17, 4-bit counters wrap to 1
    n_ok = 0;
    for (int i = 0; i < 17; i++) begin
      push(24'h400000 + 24'(i), 1'b1, 8, ok);
      if (ok) n_ok++;
    end
    chk("t6_pushes", n_ok, 17);
    drain(2000);
    chk("t6_sent16", bus.ov_sent_count, 17);
    chk("t6_recv16", bus.ov_recv_count, 17);
    chk("t6_sent4_wrap", bus2.ov_sent_count, 1);
    chk("t6_recv4_wrap", bus2.ov_recv_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_stream_sequencer.md
Name: fir_stream_sequencer

Overview:
- Counterpart of the FIR filter's valid/consumed input port and valid/ready output port.
- Buffers upstream samples in a FIFO and feeds them one at a time to a single FIR filter instance.
- Waits for each filter result, acknowledges it, and forwards it on a downstream valid/ready stream.
- Maintains sent/received counters and a sticky watchdog error for a filter that never answers.

Parameters:
DATA_WIDTH, 24, sample and result width in bits
FIFO_DEPTH, 16, input FIFO entries; must be a power of 2, minimum 2
TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before the watchdog fires
CNT_WIDTH, 16, width of the sent and received counters

Ports:
i_clk  in  1  clock; all logic is rising-edge
i_rst  in  1  synchronous reset, active-high
iv_s_data  in  DATA_WIDTH  upstream sample
i_s_valid  in  1  upstream sample valid
o_s_ready  out  1  FIFO can accept; transfer occurs when i_s_valid && o_s_ready
ov_fir_din  out  DATA_WIDTH  sample presented to the filter
o_fir_din_valid  out  1  sample valid to the filter
i_fir_consumed  in  1  one-cycle pulse from the filter: sample taken
iv_fir_dout  in  DATA_WIDTH  filter result
i_fir_dout_valid  in  1  filter result valid
o_fir_dout_ready  out  1  one-cycle acknowledge of the filter result
ov_m_data  out  DATA_WIDTH  downstream result
o_m_valid  out  1  downstream result valid
i_m_ready  in  1  downstream accepts
i_err_clr  in  1  clears o_timeout_err
o_timeout_err  out  1  sticky watchdog error
ov_sent_count  out  CNT_WIDTH  samples consumed by the filter
ov_recv_count  out  CNT_WIDTH  results acknowledged

Behaviour:
- Reset: i_rst is synchronous, active-high, clocked on i_clk. State returns to IDLE and the FIFO is emptied. All outputs registered to 0, including ov_fir_din and ov_m_data. o_s_ready is forced to 0 while i_rst is high.
- FIFO: registered read/write pointers and count.
  - o_s_ready = !full, combinational from the registered count.
  - When full, ready stays low even if a pop occurs in the same cycle; there is no bypass.
  - A push and a pop may occur in the same cycle when the FIFO is neither empty nor full.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SEND, WAIT, ACK, OUT.
- IDLE:
  - If the FIFO is not empty: pop the head, register it into ov_fir_din, set o_fir_din_valid to 1, go to SEND.
  - A sample pushed into an empty FIFO at edge t appears with o_fir_din_valid=1 after edge t+2.
- SEND:
  - Hold ov_fir_din and o_fir_din_valid stable.
  - On i_fir_consumed=1: clear o_fir_din_valid, increment ov_sent_count, clear the timer, go to WAIT.
  - No timeout applies in SEND.
- WAIT:
  - The timer increments every cycle.
  - If i_fir_dout_valid=1: capture iv_fir_dout into ov_m_data and set o_fir_dout_ready to 1, effective the next cycle. Go to ACK.
  - Else if timer == TIMEOUT_CYCLES-1: set o_timeout_err, discard the sample, go to IDLE.
  - Valid takes priority over timeout when both occur in the same cycle.
- ACK:
  - o_fir_dout_ready is high for exactly this one cycle and deasserts on exit.
  - Increment ov_recv_count, set o_m_valid to 1, go to OUT.
- OUT:
  - Hold ov_m_data and o_m_valid stable until i_m_ready=1.
  - On i_m_ready=1: clear o_m_valid, go to IDLE. This leaves a one-cycle bubble before the next pop.
- Only one sample is in flight at a time. The filter contract is that i_fir_dout_valid drops after the acknowledge.
- i_fir_consumed and i_fir_dout_valid are ignored outside SEND and WAIT respectively.
- Counters wrap modulo 2^CNT_WIDTH.
- o_timeout_err is cleared by i_err_clr. If a timeout and i_err_clr occur in the same cycle, the set wins.
- Reset mid-operation: any in-flight sample, FIFO contents, and result are dropped. No acknowledge is issued.

Test Plan:
- Single sample: push 0x000123; filter model pulses consumed 3 cycles later and returns 0x000456 after 20 cycles → o_fir_din_valid rises 2 cycles after push, ov_sent_count=1, o_fir_dout_ready one cycle, ov_m_data=0x000456, ov_recv_count=1.
- FIFO full: push 16 samples with the filter stalled (consumed never asserted) → first sample popped, remaining 15 held. Further pushes fill the FIFO back to 16 entries, o_s_ready=0, and the 17th push is blocked. Release the filter → all samples emerge in order.
- Timeout: sample sent, filter never returns a result → o_timeout_err=1 exactly 64 cycles after entering WAIT, FSM in IDLE, ov_recv_count unchanged. Next sample proceeds normally. i_err_clr clears the error.
- Downstream backpressure: hold i_m_ready=0 for 10 cycles → ov_m_data/o_m_valid stable, no new sample sent to the filter, FIFO keeps accepting.
- Reset mid-WAIT: assert i_rst with 3 samples queued → all outputs 0, FIFO empty, o_s_ready=0 during reset and 1 after.
- Counter wrap with CNT_WIDTH=4: 17 full round trips → ov_sent_count=1, ov_recv_count=1.
